instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction fetch unit; the producer end of the `instr`/`incr` interface that the RISC-V decoder consumes.
- Holds the program counter and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Presents one fetched 32-bit instruction at a time to the decoder with a valid/ready handshake.
- Advances the PC when the instruction is consumed: +4 on `incr`, or to a target on `branch_en`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, value driven on `instr` while no valid instruction is held (addi x0,x0,0).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- n_reset  input  1  synchronous, active-low reset
- imem_req  output  1  memory request valid
- imem_addr  output  32  word address of request (byte address, [1:0]=0)
- imem_gnt  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- instr  output  32  instruction to decoder
- instr_valid  output  1  `instr` holds a fetched instruction
- instr_ready  input  1  decoder/execute consumes `instr` this cycle
- incr  input  1  from decoder: advance PC by 4 on consume
- branch_en  input  1  on consume: load PC from branch_target (priority over incr)
- branch_target  input  32  next PC when branch_en
- pc  output  32  address of instruction currently held/being fetched

Behaviour:
- Reset: one clock; synchronous, active-low (`n_reset`) — sampled on `clock` rising edge.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, instr_valid=0, state=FETCH.
- FSM states: FETCH, WAIT, HOLD.
- FETCH: imem_req=1, imem_addr=pc (combinational from pc).
  - imem_gnt=1 -> WAIT.
  - Otherwise stay in FETCH with req held; addr stable while req high.
- WAIT: imem_req=0.
  - imem_rvalid=1 -> register imem_rdata into instr, instr_valid=1 next cycle, -> HOLD.
- HOLD: instr_valid=1, instr stable.
  - instr_valid & instr_ready -> clear instr_valid (instr returns to NOP_INSTR), update pc, -> FETCH.
- PC update on consume only:
  - branch_en=1 -> branch_target.
  - else incr=1 -> pc+4.
  - else pc unchanged (replay same address).
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- branch_target[1:0] ignored (forced 0) unless the optional feature is enabled.
- imem_rvalid in FETCH or HOLD is ignored (stale response after reset, spurious data).
- imem_gnt outside FETCH is ignored.
- incr/branch_en/branch_target are sampled only in the consume cycle.
- Latency: gnt in cycle N, rvalid in N+1 -> instr_valid in N+2. Minimum 3 cycles per instruction at zero memory wait and instr_ready tied high.
- Single outstanding request; no second request is issued before rvalid.
- Reset mid-operation (any state): all outputs return to reset values next edge; any outstanding response is dropped.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output `misalign` (1 bit, reset 0).
  - On consume with branch_en=1 and branch_target[1:0]!=0: pc is not updated, misalign=1, FSM enters HALT.
  - HALT: imem_req=0, instr_valid=0; exited only by reset.
- Not defined:
  - No `misalign` port.
  - branch_target[1:0] is forced to 0 and fetch continues at the aligned address.

Test Plan:
- Reset release, imem_gnt=1 immediately, rvalid next cycle with rdata=32'h00A00093, instr_ready=1, incr=1 -> imem_addr=0x0 in cycle 1; instr=32'h00A00093 with instr_valid in cycle 3; next imem_addr=0x4.
- Back-pressure: instr_ready=0 for 5 cycles in HOLD -> instr, instr_valid and pc stable; no imem_req; consume on cycle 6 -> pc=0x4.
- Branch: consume with branch_en=1, incr=1, branch_target=0x100 -> next imem_addr=0x100 (branch wins); with incr=0, branch_en=0 -> imem_addr repeats the current pc.
- Wrap: RESET_PC=32'hFFFF_FFFC, consume with incr=1 -> pc=32'h0000_0000.
- Memory stall: imem_gnt low 4 cycles -> imem_req high with fixed imem_addr; spurious imem_rvalid=1 during FETCH -> no instr_valid.
- Reset in WAIT, then rvalid arrives the cycle after reset -> ignored; instr=NOP_INSTR, instr_valid=0, imem_addr=RESET_PC. With IFETCH_MISALIGN_TRAP_EN defined, branch_target=0x102 -> misalign=1, imem_req stays 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/gnt/rvalid
// and holds it for the decoder until consumed. Define IFETCH_MISALIGN_TRAP_EN to trap misaligned branches.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        n_reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        incr,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic [1:0]  dbg_state
);

   // Handshakes: a memory request transfers when imem_req & imem_gnt are both high on a
   // rising edge; the decoder consumes instr when instr_valid & instr_ready are both high.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        req_d;
   logic [31:0] target_aligned;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        misalign_q, misalign_d;
`endif

   assign target_aligned = branch_target & 32'hFFFF_FFFC;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      req_d         = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_d    = misalign_q;
`endif
      case (state_q)
         ST_FETCH: begin
            req_d = 1'b1;
            if (imem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (instr_valid_q && instr_ready) begin
               instr_d       = NOP_INSTR;
               instr_valid_d = 1'b0;
               state_d       = ST_FETCH;
               if (branch_en) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                  if (branch_target[1:0] != 2'b00) begin
                     misalign_d = 1'b1;
                     state_d    = ST_HALT;
                  end else begin
                     pc_d = target_aligned;
                  end
`else
                  pc_d = target_aligned;
`endif
               end else if (incr) begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         ST_HALT: begin
            // Only reset leaves this state.
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   // The request is masked while reset is held so the bus sees no request during reset.
   assign imem_req    = req_d & n_reset;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign dbg_state   = state_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misalign    = misalign_q;
`endif

endmodule
